// File: rtl/bubble_sort_ctrl.sv
// Streaming bubble sorter: loads N elements, sorts them with one compare-swap
// per cycle, then unloads in ascending order. Define SORT_EARLY_EXIT_EN to end early on a swap-free pass.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_LOAD   | accepting elements into mem at ld_cnt, in_ready high
// S_SORT   | one compare-swap of mem[j], mem[j+1] per cycle, busy high
// S_UNLOAD | presenting mem[k] with out_valid until accepted downstream
module bubble_sort_ctrl #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] LAST_EL   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_UNLOAD
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  mem_q [N];
  logic [WIDTH-1:0]  mem_d [N];

  logic [IW-1:0]     ld_idx, j_idx, jn_idx, k_idx;
  logic [WIDTH-1:0]  elem_a, elem_b;
  logic [CW-1:0]     j_end;
  logic              swap;
  logic              sort_done;

  assign ld_idx = ld_cnt_q[IW-1:0];
  assign j_idx  = j_q[IW-1:0];
  assign jn_idx = j_idx + IW'(1);
  assign k_idx  = k_q[IW-1:0];
  assign elem_a = mem_q[j_idx];
  assign elem_b = mem_q[jn_idx];
  // Strict compare keeps equal elements in place.
  assign swap   = elem_a > elem_b;
  assign j_end  = LAST_PASS - i_q;

`ifdef SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;

  // A pass with no swaps (including the compare in flight) means sorted.
  assign sort_done = (i_q == LAST_PASS) || !(swapped_q || swap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swapped_q <= 1'b0;
    end else begin
      swapped_q <= swapped_d;
    end
  end

  always_comb begin
    swapped_d = 1'b0;
    if (state_q == S_SORT && j_q != j_end) begin
      swapped_d = swapped_q || swap;
    end
  end
`else
  assign sort_done = (i_q == LAST_PASS);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      ld_cnt_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      for (int n = 0; n < N; n++) begin
        mem_q[n] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[ld_idx] = in_data;
          if (ld_cnt_q == LAST_EL) begin
            state_d  = S_SORT;
            ld_cnt_d = '0;
            i_d      = '0;
            j_d      = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end

      S_SORT: begin
        busy = 1'b1;
        if (swap) begin
          mem_d[j_idx]  = elem_b;
          mem_d[jn_idx] = elem_a;
        end
        if (j_q == j_end) begin
          j_d = '0;
          if (sort_done) begin
            state_d = S_UNLOAD;
            i_d     = '0;
            k_d     = '0;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end

      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem_q[k_idx];
        out_last  = (k_q == LAST_EL);
        if (out_ready) begin
          if (k_q == LAST_EL) begin
            state_d  = S_LOAD;
            ld_cnt_d = '0;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

endmodule
